// File: rtl/dht_pkg.sv
// dht_pkg: shared types and constants for the single-wire sensor reader.
// Holds the FSM state enum, error codes, frame length and checksum helper.
package dht_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_LOW,
        S_REL,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_CHECK,
        S_DONE
    } dht_state_e;

    localparam logic [1:0] DHT_OK       = 2'b00;
    localparam logic [1:0] DHT_TIMEOUT  = 2'b01;
    localparam logic [1:0] DHT_CHECKSUM = 2'b10;

    localparam int DHT_FRAME_BITS = 40;

    // Sum of the four payload bytes, modulo 256 (byte 0 in the top bits).
    function automatic logic [7:0] dht_sum(input logic [39:0] f);
        return f[39:32] + f[31:24] + f[23:16] + f[15:8];
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus one edge flop.
// Ports: clk_i, rst_i (async high), async_i in; rise_o, fall_o one-cycle pulses.
module sync_edge_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    // [0],[1] synchronize; [2] holds the previous synced value.
    logic [2:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {3{RST_VAL}};
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/dht_reader.sv
// dht_reader: runs the host start pulse, times the sensor response and 40 data
// bits in 1 us ticks, and publishes humidity/temperature with done + error code.
// Ports: i_clk, i_rst (async high), i_tick (1 MHz), i_start, i_data (sensor line);
// o_data_oe (drive low), o_busy, o_done, o_error, o_humidity, o_temperature.
// Build option: DHT_READER_CHECKSUM_EN enables checksum verification of byte 4.
module dht_reader
    import dht_pkg::*;
#(
    parameter int C_TIMER_BITS    = 11,
    parameter int C_START_US      = 1000,
    parameter int C_TIMEOUT_US    = 200,
    parameter int C_BIT_THRESH_US = 48
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tick,
    input  logic        i_start,
    input  logic        i_data,
    output logic        o_data_oe,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_error,
    output logic [15:0] o_humidity,
    output logic [15:0] o_temperature
);

    localparam logic [C_TIMER_BITS-1:0] T_START   = C_TIMER_BITS'(C_START_US);
    localparam logic [C_TIMER_BITS-1:0] T_TIMEOUT = C_TIMER_BITS'(C_TIMEOUT_US);
    localparam logic [C_TIMER_BITS-1:0] T_THRESH  = C_TIMER_BITS'(C_BIT_THRESH_US);
    localparam logic [C_TIMER_BITS-1:0] T_MAX     = '1;
    localparam logic [5:0]              N_BITS    = 6'(DHT_FRAME_BITS);

    dht_state_e              state_q, state_d;
    logic [C_TIMER_BITS-1:0] timer_q, timer_d;
    logic [39:0]             shift_q, shift_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [1:0]              err_q, err_d;
    logic [15:0]             hum_q, hum_d;
    logic [15:0]             temp_q, temp_d;

    logic tick;
    logic tick_fall_unused;
    logic d_rise;
    logic d_fall;
    logic timed_out;
    logic bit_val;
    logic [5:0] cnt_inc;
    logic sum_ok;

    sync_edge_detect #(.RST_VAL(1'b0)) u_tick_sync (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .async_i (i_tick),
        .rise_o  (tick),
        .fall_o  (tick_fall_unused)
    );

    // Line idles high (external pull-up), so reset the synchronizer high.
    sync_edge_detect #(.RST_VAL(1'b1)) u_data_sync (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .async_i (i_data),
        .rise_o  (d_rise),
        .fall_o  (d_fall)
    );

    assign timed_out = (timer_q >= T_TIMEOUT);
    assign bit_val   = (timer_q > T_THRESH);
    assign cnt_inc   = cnt_q + 6'd1;

`ifdef DHT_READER_CHECKSUM_EN
    assign sum_ok = (dht_sum(shift_q) == shift_q[7:0]);
`else
    logic [7:0] chk_byte_unused;
    assign chk_byte_unused = shift_q[7:0];
    assign sum_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        hum_d   = hum_q;
        temp_d  = temp_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_START_LOW;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            S_START_LOW: begin
                if (timer_q == T_START) state_d = S_REL;
            end
            S_REL: begin
                if (d_fall) begin
                    state_d = S_RESP_LOW;
                end else if (timed_out) begin
                    state_d = S_DONE;
                    err_d   = DHT_TIMEOUT;
                end
            end
            S_RESP_LOW: begin
                if (d_rise) begin
                    state_d = S_RESP_HIGH;
                end else if (timed_out) begin
                    state_d = S_DONE;
                    err_d   = DHT_TIMEOUT;
                end
            end
            S_RESP_HIGH: begin
                if (d_fall) begin
                    state_d = S_BIT_LOW;
                end else if (timed_out) begin
                    state_d = S_DONE;
                    err_d   = DHT_TIMEOUT;
                end
            end
            S_BIT_LOW: begin
                if (d_rise) begin
                    state_d = S_BIT_HIGH;
                end else if (timed_out) begin
                    state_d = S_DONE;
                    err_d   = DHT_TIMEOUT;
                end
            end
            S_BIT_HIGH: begin
                // The high-phase length decides the bit value.
                if (d_fall) begin
                    shift_d = {shift_q[38:0], bit_val};
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == N_BITS) ? S_CHECK : S_BIT_LOW;
                end else if (timed_out) begin
                    state_d = S_DONE;
                    err_d   = DHT_TIMEOUT;
                end
            end
            S_CHECK: begin
                state_d = S_DONE;
                if (sum_ok) begin
                    err_d  = DHT_OK;
                    hum_d  = shift_q[39:24];
                    temp_d = shift_q[23:8];
                end else begin
                    err_d  = DHT_CHECKSUM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A state change restarts the timer, even if a tick lands the same cycle.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick && timer_q != T_MAX) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            err_q   <= DHT_OK;
            hum_q   <= '0;
            temp_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            hum_q   <= hum_d;
            temp_q  <= temp_d;
        end
    end

    // Decoded from the state register so reset releases the line at once.
    assign o_data_oe     = (state_q == S_START_LOW);
    assign o_busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done        = (state_q == S_DONE);
    assign o_error       = err_q;
    assign o_humidity    = hum_q;
    assign o_temperature = temp_q;

endmodule

// File: tb/tb_dht_reader.sv
// tb_dht_reader: sensor line model driving dht_reader with randomized phase
// lengths; expected words and error codes come from a byte-level frame model.
module tb_dht_reader;

    logic        clk;
    logic        rst;
    logic        i_tick;
    logic        i_start;
    logic        i_data;
    logic        sens;
    logic        o_data_oe;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_error;
    logic [15:0] o_humidity;
    logic [15:0] o_temperature;

    dht_reader dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_tick        (i_tick),
        .i_start       (i_start),
        .i_data        (i_data),
        .o_data_oe     (o_data_oe),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_humidity    (o_humidity),
        .o_temperature (o_temperature)
    );

    // Open-drain line: host pulls low when oe, otherwise sensor level.
    assign i_data = ~o_data_oe & sens;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1 MHz tick = 4 clock cycles.
    initial begin
        i_tick = 1'b0;
        #7;
        forever begin
            i_tick = 1'b1;
            #20;
            i_tick = 1'b0;
            #20;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Passive monitor: oe pulse lengths and captured completion values.
    int          cyc = 0;
    int          oe_rise = 0;
    int          oe_len = 0;
    int          rel_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    logic        oe_prev = 1'b0;
    logic [1:0]  d_err;
    logic [15:0] d_hum;
    logic [15:0] d_tmp;

    always @(negedge clk) begin
        cyc++;
        if (o_data_oe && !oe_prev) oe_rise = cyc;
        if (!o_data_oe && oe_prev) begin
            oe_len  = cyc - oe_rise;
            rel_cyc = cyc;
        end
        oe_prev = o_data_oe;
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
            d_err = o_error;
            d_hum = o_humidity;
            d_tmp = o_temperature;
            chk("busy_at_done", o_busy, 0);
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference model: last good words and expected error.
    logic [15:0] m_hum = '0;
    logic [15:0] m_tmp = '0;
    logic [1:0]  m_err = 2'b00;

    task automatic model_frame(input logic [7:0] b [5]);
        int sum;
        sum = (b[0] + b[1] + b[2] + b[3]) % 256;
`ifdef DHT_READER_CHECKSUM_EN
        m_err = (sum == int'(b[4])) ? 2'd0 : 2'd2;
`else
        m_err = 2'd0;
`endif
        if (m_err == 2'd0) begin
            m_hum = {b[0], b[1]};
            m_tmp = {b[2], b[3]};
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        sens = lvl;
        repeat (n) @(posedge i_tick);
    endtask

    task automatic wait_oe(input logic lvl, input int budget,
                           input string tag);
        int n = 0;
        while (o_data_oe !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, o_data_oe, lvl);
    endtask

    task automatic wait_done(input int n0, input int budget,
                             input string tag);
        int n = 0;
        while (done_cnt == n0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(tag, done_cnt, n0 + 1);
    endtask

    // Sensor: nbits < 0 means no response; abort_bit >= 0 resets mid-frame.
    task automatic sensor(input logic [7:0] b [5], input int nbits,
                          input int abort_bit);
        logic bv;
        if (nbits < 0) return;
        hold(1'b1, $urandom_range(10, 30));
        hold(1'b0, $urandom_range(20, 40));
        hold(1'b1, $urandom_range(20, 40));
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_bit) begin
                rst = 1'b1;
                #1;
                chk("rst_oe", o_data_oe, 0);
                chk("rst_busy", o_busy, 0);
                chk("rst_hum", o_humidity, 0);
                chk("rst_tmp", o_temperature, 0);
                chk("rst_err", o_error, 0);
                @(negedge clk);
                rst = 1'b0;
                sens = 1'b1;
                m_hum = '0;
                m_tmp = '0;
                m_err = 2'd0;
                return;
            end
            if (abort_bit >= 0 && i == 5) begin
                @(negedge clk);
                i_start = 1'b1;
                @(negedge clk);
                i_start = 1'b0;
                chk("busy_ign_start", o_busy, 1);
            end
            bv = b[i / 8][7 - (i % 8)];
            hold(1'b0, $urandom_range(8, 14));
            hold(1'b1, bv ? $urandom_range(67, 73) : $urandom_range(23, 29));
        end
        if (nbits == 40) hold(1'b0, $urandom_range(8, 14));
        sens = 1'b1;
    endtask

    task automatic run_meas(input logic [7:0] b [5], input int nbits,
                            input int abort_bit);
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("oe_next", o_data_oe, 1);
        chk("busy_next", o_busy, 1);
        wait_oe(1'b0, 4200, "oe_release");
        @(negedge clk);
        chk("start_ticks", (oe_len + 2) / 4, 1000);
        sensor(b, nbits, abort_bit);
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_err"}, d_err, m_err);
        chk({tag, "_hum"}, d_hum, m_hum);
        chk({tag, "_tmp"}, d_tmp, m_tmp);
        chk({tag, "_held"}, o_error, m_err);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    logic [7:0] f [5];
    int n0;

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        sens = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_oe", o_data_oe, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_err", o_error, 0);
        chk("reset_hum", o_humidity, 0);
        chk("reset_tmp", o_temperature, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Known good frame.
        f = '{8'h02, 8'h8C, 8'h01, 8'h5F, 8'hEE};
        n0 = done_cnt;
        run_meas(f, 40, -1);
        wait_done(n0, 1200, "good_done");
        model_frame(f);
        check_result("good");

        // Same payload, corrupted checksum byte.
        f = '{8'h02, 8'h8C, 8'h01, 8'h5F, 8'hEF};
        n0 = done_cnt;
        run_meas(f, 40, -1);
        wait_done(n0, 1200, "csum_done");
        model_frame(f);
        check_result("csum");

        // No sensor response.
        n0 = done_cnt;
        run_meas(f, -1, -1);
        wait_done(n0, 1200, "noresp_done");
        m_err = 2'd1;
        check_result("noresp");
        chk("noresp_ticks", (done_cyc - rel_cyc + 2) / 4, 200);

        // Sensor stops after 17 bits, line left high.
        for (int i = 0; i < 5; i++) f[i] = 8'($urandom);
        n0 = done_cnt;
        run_meas(f, 17, -1);
        wait_done(n0, 1200, "stuck_done");
        m_err = 2'd1;
        check_result("stuck");

        // Ignored start during bits, then reset at bit 20.
        for (int i = 0; i < 5; i++) f[i] = 8'($urandom);
        n0 = done_cnt;
        run_meas(f, 40, 20);
        repeat (100) @(negedge clk);
        chk("abort_busy", o_busy, 0);
        chk("abort_oe", o_data_oe, 0);
        chk("abort_nodone", done_cnt, n0);

        // Clean random frame after the abort.
        for (int i = 0; i < 4; i++) f[i] = 8'($urandom);
        f[4] = 8'((f[0] + f[1] + f[2] + f[3]) % 256);
        n0 = done_cnt;
        run_meas(f, 40, -1);
        wait_done(n0, 1200, "clean_done");
        model_frame(f);
        check_result("clean");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
